// File: rtl/i_wr_counter.sv
// rtl/i_wr_counter.sv - column counter with programmable width and one-cycle wrap flag
module i_wr_counter (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        clear,
  input  logic        count_enable,
  input  logic [12:0] rollover_val,
  output logic [12:0] value,
  output logic        rollover_flag
);

  logic [13:0] value_inc;
  logic        at_limit;
  logic [12:0] next_value;
  logic        next_flag;

  // 14-bit compare keeps widths 0 and 1 identical and avoids underflow of rollover_val-1
  assign value_inc = {1'b0, value} + 14'd1;
  assign at_limit  = (value_inc >= {1'b0, rollover_val});

  always_comb begin
    next_value = value;
    next_flag  = 1'b0;
    if (clear) begin
      next_value = 13'd0;
    end else if (count_enable) begin
      if (at_limit) begin
        next_value = 13'd0;
        next_flag  = 1'b1;
      end else begin
        next_value = value_inc[12:0];
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      value         <= 13'd0;
      rollover_flag <= 1'b0;
    end else begin
      value         <= next_value;
      rollover_flag <= next_flag;
    end
  end

endmodule

// File: tb/tb_i_wr_counter.sv
// tb/tb_i_wr_counter.sv - self-checking bench for i_wr_counter
module tb_i_wr_counter;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        clear = 1'b0;
  logic        count_enable = 1'b0;
  logic [12:0] rollover_val = 13'd10;
  logic [12:0] value;
  logic        rollover_flag;

  int total = 0;
  int bad = 0;
  bit chk_on = 1'b0;

  int m_val = 0;
  int m_flag = 0;

  i_wr_counter dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (clear),
    .count_enable (count_enable),
    .rollover_val (rollover_val),
    .value        (value),
    .rollover_flag(rollover_flag)
  );

  always #5 clk = ~clk;

  // Model: column index modulo the width (width 0 treated as 1); wrap raises a one-cycle flag
  always @(posedge clk or negedge n_rst) begin
    int width;
    width = (rollover_val == 13'd0) ? 1 : int'(rollover_val);
    if (!n_rst) begin
      m_val = 0;
      m_flag = 0;
    end else if (clear) begin
      m_val = 0;
      m_flag = 0;
    end else if (count_enable) begin
      if (m_val + 1 >= width) begin
        m_val = 0;
        m_flag = 1;
      end else begin
        m_val = m_val + 1;
        m_flag = 0;
      end
    end else begin
      m_flag = 0;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      total++;
      if (int'(value) != m_val || int'(rollover_flag) != m_flag) begin
        bad++;
        $display("FAIL model_cmp t=%0t value=%0d flag=%0d required value=%0d flag=%0d",
                 $time, value, rollover_flag, m_val, m_flag);
      end
    end
  end

  task automatic check(input string name, input int act_v, input int act_f,
                       input int exp_v, input int exp_f);
    total++;
    if (act_v != exp_v || act_f != exp_f) begin
      bad++;
      $display("FAIL %s value=%0d flag=%0d required value=%0d flag=%0d",
               name, act_v, act_f, exp_v, exp_f);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step_en();
    count_enable = 1'b1;
    tick();
    count_enable = 1'b0;
  endtask

  task automatic sweep(input int n);
    rollover_val = 13'(n);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    for (int i = 1; i <= n + 1; i++) begin
      for (int k = 0; k < 3; k++) begin
        tick();
        if (i == n + 1 && k == 0)
          check("flag_drop_after_wrap", int'(value), int'(rollover_flag), 0, 0);
      end
      step_en();
      if (i < n)
        check("sweep_count", int'(value), int'(rollover_flag), i, 0);
      else if (i == n)
        check("sweep_wrap", int'(value), int'(rollover_flag), 0, 1);
      else
        check("sweep_after_wrap", int'(value), int'(rollover_flag), 1, 0);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) tick();
    chk_on = 1'b1;
    check("reset_state", int'(value), int'(rollover_flag), 0, 0);
    n_rst = 1'b1;
    tick();

    // clear after a few counts
    repeat (3) step_en();
    check("pre_clear", int'(value), int'(rollover_flag), 3, 0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clear", int'(value), int'(rollover_flag), 0, 0);

    sweep(10);
    sweep(100);
    sweep(8191);

    // clear beats enable at value 5
    rollover_val = 13'd10;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    repeat (5) step_en();
    check("at_five", int'(value), int'(rollover_flag), 5, 0);
    clear = 1'b1;
    count_enable = 1'b1;
    tick();
    clear = 1'b0;
    count_enable = 1'b0;
    check("clear_priority", int'(value), int'(rollover_flag), 0, 0);

    // width shrink mid-row forces a wrap
    repeat (7) step_en();
    rollover_val = 13'd4;
    step_en();
    check("shrink_wrap", int'(value), int'(rollover_flag), 0, 1);
    rollover_val = 13'd10;
    tick();

    // async reset mid-count at value 7
    repeat (7) step_en();
    check("pre_reset", int'(value), int'(rollover_flag), 7, 0);
    #2;
    n_rst = 1'b0;
    #1;
    check("async_reset", int'(value), int'(rollover_flag), 0, 0);
    tick();
    n_rst = 1'b1;
    tick();
    step_en();
    check("restart", int'(value), int'(rollover_flag), 1, 0);

    // degenerate widths 1 and 0
    for (int w = 1; w >= 0; w--) begin
      rollover_val = 13'(w);
      for (int r = 0; r < 3; r++) begin
        step_en();
        check("degen_en", int'(value), int'(rollover_flag), 0, 1);
        tick();
        check("degen_idle", int'(value), int'(rollover_flag), 0, 0);
      end
    end

    tick();
    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
